machine_timer: RTL and testbench
================================

MACHINE_TIMER -- requirements
Module: machine_timer

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h80000000, word-aligned base of the four timer registers.
REQ-002 SHALL have parameter PRESCALE, default 24, clk24 cycles per mtime tick (1 MHz tick); legal range 1..65535.
REQ-003 SHALL have port clk24  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port memory_address  input  32  core data address, byte granularity.
REQ-006 SHALL have port memory_write_value  input  32  write data, already lane-shifted to address[1:0].
REQ-007 SHALL have port memory_write_sections  input  4  byte-lane write enables; 0 = no write.
REQ-008 SHALL have port read_value  output  32  registered read data.
REQ-009 SHALL have port read_hit  output  1  registered; 1 = read_value belongs to this block.
REQ-010 SHALL have port mip_mtip  output  1  machine timer interrupt pending.

Function
REQ-011 SHALL decode on memory_address[31:2]: BASE+0 MTIME (mtime[31:0]), BASE+4 MTIMEH (mtime[63:32]), BASE+8 MTIMECMP (mtimecmp[31:0]), BASE+12 MTIMECMPH (mtimecmp[63:32]); other addresses ignored.
REQ-012 SHALL keep a prescaler counter 0..PRESCALE-1; at PRESCALE-1 it wraps to 0 and asserts tick for that cycle.
REQ-013 SHALL increment 64-bit mtime by 1 on each tick, full 64-bit carry; 64'hFFFFFFFFFFFFFFFF wraps to 0.
REQ-014 SHALL apply writes per byte lane: enabled lanes take memory_write_value, disabled lanes hold current value.
REQ-015 SHALL, on any write (sections != 0) to MTIME or MTIMEH, suppress that cycle's increment entirely (write wins over tick, no carry into the other half) and reset the prescaler to 0.
REQ-016 SHALL NOT alter mtime or prescaler on reads or on writes to MTIMECMP/MTIMECMPH.
REQ-017 SHALL present read data one cycle after address: read_value <= selected register, read_hit <= 1 on a decoded address; otherwise read_value <= 0, read_hit <= 0.
REQ-018 SHALL, on a read of MTIME, capture mtime[63:32] into a 32-bit shadow in the same edge that registers read_value.
REQ-019 SHALL return the shadow, not live mtime[63:32], for a read of MTIMEH; low-then-high reads are thus tear-free across carries.
REQ-020 SHALL return register contents from before any same-cycle write (read-before-write).
REQ-021 SHALL drive mip_mtip combinationally as unsigned mtime >= mtimecmp from current registered values.
REQ-022 SHALL NOT latch mip_mtip; it clears when mtimecmp is raised above mtime or mtime wraps below mtimecmp.
REQ-023 SHALL treat a write with sections != 0 and a read to the same address in one cycle as both taking effect per REQ-014/REQ-020.

Reset
REQ-024 SHALL on reset assertion immediately set mtime=0, mtimecmp=64'hFFFFFFFFFFFFFFFF, prescaler=0, shadow=0, read_value=0, read_hit=0; mip_mtip=0 follows.
REQ-025 SHALL hold all state while reset is high and resume counting from prescaler 0 on the first edge after deassertion.
REQ-026 SHALL abandon any in-progress read or tick when reset asserts mid-operation; no partial update survives.

Verification
REQ-027 SHALL verify tick: PRESCALE=24, reset release, idle 48 cycles -> mtime=2, mip_mtip=0.
REQ-028 SHALL verify carry read: write MTIME=FFFFFFFF, MTIMEH=00000001; read MTIME across the carry tick, then MTIMEH -> MTIMEH read returns 00000001 while live mtime[63:32]=2.
REQ-029 SHALL verify lane write: MTIMECMP=0, then write 0xAB00 with sections 4'b0010 -> MTIMECMP reads 0x0000AB00.
REQ-030 SHALL verify interrupt: mtimecmp=5, mtime=4 -> mip_mtip rises on the tick making mtime=5; writing MTIMECMPH=1 drops it next cycle.
REQ-031 SHALL verify collision: write MTIME=0x10 on the tick cycle -> mtime=0x10 (not 0x11), next tick after PRESCALE further cycles.
REQ-032 SHALL verify mid-operation reset: reset pulsed during a pending MTIME read -> read_hit=0, read_value=0, mtime=0, mtimecmp all ones.

Source files
------------

// File: rtl/machine_timer.sv
// Memory-mapped RISC-V machine timer: a 64-bit mtime counter advanced by a
// clock prescaler, a 64-bit mtimecmp compare register, byte-lane writes,
// registered reads with a tear-free high-word shadow, and the mip.MTIP flag.
module machine_timer #(
  parameter logic [31:0] BASE_ADDRESS = 32'h80000000,
  parameter int          PRESCALE     = 24
) (
  input  logic        clk24,
  input  logic        reset,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_write_value,
  input  logic [3:0]  memory_write_sections,
  output logic [31:0] read_value,
  output logic        read_hit,
  output logic        mip_mtip
);

  localparam logic [15:0] PRE_MAX  = 16'(PRESCALE - 1);
  localparam logic [29:0] BASE_W   = BASE_ADDRESS[31:2];
  localparam logic [29:0] W_MTIME  = BASE_W + 30'd0;
  localparam logic [29:0] W_MTIMEH = BASE_W + 30'd1;
  localparam logic [29:0] W_CMP    = BASE_W + 30'd2;
  localparam logic [29:0] W_CMPH   = BASE_W + 30'd3;

  // Enabled byte lanes take the new data, the others keep the old value.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sec);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sec[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [15:0] r_prescale;
  logic [31:0] r_shadow;
  logic [31:0] r_read_value;
  logic        r_read_hit;

  logic [29:0] w_word;
  logic        w_write;
  logic        w_sel_lo;
  logic        w_sel_hi;
  logic        w_sel_cmp;
  logic        w_sel_cmph;
  logic        w_tick;
  logic        w_unused_addr_lsb;

  assign w_word            = memory_address[31:2];
  assign w_unused_addr_lsb = ^memory_address[1:0];
  assign w_write           = (memory_write_sections != 4'b0000);
  assign w_sel_lo          = (w_word == W_MTIME);
  assign w_sel_hi          = (w_word == W_MTIMEH);
  assign w_sel_cmp         = (w_word == W_CMP);
  assign w_sel_cmph        = (w_word == W_CMPH);
  assign w_tick            = (r_prescale == PRE_MAX);

  // mtime and prescaler: a write to either mtime half beats the tick and restarts the prescaler.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      r_mtime    <= 64'd0;
      r_prescale <= 16'd0;
    end else if (w_write && (w_sel_lo || w_sel_hi)) begin
      r_prescale <= 16'd0;
      if (w_sel_lo) begin
        r_mtime[31:0] <= lane_merge(r_mtime[31:0], memory_write_value, memory_write_sections);
      end else begin
        r_mtime[63:32] <= lane_merge(r_mtime[63:32], memory_write_value, memory_write_sections);
      end
    end else if (w_tick) begin
      r_prescale <= 16'd0;
      r_mtime    <= r_mtime + 64'd1;
    end else begin
      r_prescale <= r_prescale + 16'd1;
    end
  end

  // mtimecmp: byte-lane writes to either half, otherwise hold.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      r_mtimecmp <= 64'hFFFFFFFFFFFFFFFF;
    end else if (w_write && w_sel_cmp) begin
      r_mtimecmp[31:0] <= lane_merge(r_mtimecmp[31:0], memory_write_value, memory_write_sections);
    end else if (w_write && w_sel_cmph) begin
      r_mtimecmp[63:32] <= lane_merge(r_mtimecmp[63:32], memory_write_value, memory_write_sections);
    end else begin
      r_mtimecmp <= r_mtimecmp;
    end
  end

  // Registered read port; reading MTIME snapshots the high word so a following MTIMEH read cannot tear.
  always_ff @(posedge clk24 or posedge reset) begin
    if (reset) begin
      r_read_value <= 32'd0;
      r_read_hit   <= 1'b0;
      r_shadow     <= 32'd0;
    end else begin
      r_read_hit <= w_sel_lo | w_sel_hi | w_sel_cmp | w_sel_cmph;
      if (w_sel_lo) begin
        r_shadow <= r_mtime[63:32];
      end else begin
        r_shadow <= r_shadow;
      end
      case (1'b1)
        w_sel_lo:   r_read_value <= r_mtime[31:0];
        w_sel_hi:   r_read_value <= r_shadow;
        w_sel_cmp:  r_read_value <= r_mtimecmp[31:0];
        w_sel_cmph: r_read_value <= r_mtimecmp[63:32];
        default:    r_read_value <= 32'd0;
      endcase
    end
  end

  assign read_value = r_read_value;
  assign read_hit   = r_read_hit;
  assign mip_mtip   = (r_mtime >= r_mtimecmp);

endmodule

// File: tb/tb_machine_timer.sv
// Directed bench for machine_timer: reads push expected data into a
// scoreboard queue, a negedge monitor pops and compares on every read_hit.
module tb_machine_timer;

  localparam logic [31:0] A_MTIME  = 32'h80000000;
  localparam logic [31:0] A_MTIMEH = 32'h80000004;
  localparam logic [31:0] A_CMP    = 32'h80000008;
  localparam logic [31:0] A_CMPH   = 32'h8000000C;

  logic        clk24 = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] memory_address = 32'h0;
  logic [31:0] memory_write_value = 32'h0;
  logic [3:0]  memory_write_sections = 4'h0;
  logic [31:0] read_value;
  logic        read_hit;
  logic        mip_mtip;

  int total = 0;
  int bad   = 0;
  int rd_id = 0;

  logic [31:0] q_val[$];
  bit          q_chk[$];
  int          q_id[$];

  machine_timer #(.BASE_ADDRESS(32'h80000000), .PRESCALE(24)) dut (
    .clk24                 (clk24),
    .reset                 (reset),
    .memory_address        (memory_address),
    .memory_write_value    (memory_write_value),
    .memory_write_sections (memory_write_sections),
    .read_value            (read_value),
    .read_hit              (read_hit),
    .mip_mtip              (mip_mtip)
  );

  always #5 clk24 = ~clk24;

  // Monitor: every read_hit consumes one scoreboard entry.
  always @(negedge clk24) begin
    if (!reset && read_hit) begin
      if (q_val.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_hit: got read_value=%h with no read pending", read_value);
      end else begin
        logic [31:0] ev;
        bit          ck;
        int          id;
        ev = q_val.pop_front();
        ck = q_chk.pop_front();
        id = q_id.pop_front();
        if (ck) begin
          total++;
          if (read_value !== ev) begin
            bad++;
            $display("FAIL read#%0d: got %h expected %h", id, read_value, ev);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    total++;
    if (got !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp_v);
    end
  endtask

  // One bus cycle: drive inputs, pass one rising edge, return idle.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input bit chk, input logic [31:0] exp_v);
    logic [31:0] av;
    av = a;
    memory_address        = a;
    memory_write_value    = d;
    memory_write_sections = s;
    if (av[31:4] == 28'h8000000) begin
      q_val.push_back(exp_v);
      q_chk.push_back(chk);
      q_id.push_back(rd_id);
      rd_id++;
    end
    @(posedge clk24);
    #1;
    memory_address        = 32'h0;
    memory_write_value    = 32'h0;
    memory_write_sections = 4'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_v);
    step(a, 32'h0, 4'h0, 1'b1, exp_v);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    step(a, d, s, 1'b0, 32'h0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk24);
    #1;
    check("rst_read_value", read_value, 32'h0);
    check("rst_read_hit", {31'h0, read_hit}, 32'h0);
    check("rst_mip", {31'h0, mip_mtip}, 32'h0);
    reset = 1'b0;

    // Tick: 48 idle cycles -> mtime = 2
    idle(48);
    check("tick_mip", {31'h0, mip_mtip}, 32'h0);
    rd(A_MTIME, 32'h2);
    rd(A_MTIMEH, 32'h0);

    // Carry read: low read on the carry tick, high read returns the shadow
    wr(A_MTIME, 32'hFFFFFFFF, 4'hF);
    wr(A_MTIMEH, 32'h00000001, 4'hF);
    idle(23);
    rd(A_MTIME, 32'hFFFFFFFF);
    rd(A_MTIMEH, 32'h00000001);
    rd(A_MTIME, 32'h00000000);
    rd(A_MTIMEH, 32'h00000002);

    // Lane writes into MTIMECMP
    wr(A_CMP, 32'h0, 4'hF);
    wr(A_CMP, 32'h0000AB00, 4'b0010);
    rd(A_CMP, 32'h0000AB00);
    wr(A_CMP, 32'h12000000, 4'b1000);
    rd(A_CMP, 32'h1200AB00);
    rd(A_CMPH, 32'hFFFFFFFF);

    // Interrupt: mtimecmp=5, mtime=4
    wr(A_CMP, 32'h5, 4'hF);
    wr(A_CMPH, 32'h0, 4'hF);
    wr(A_MTIMEH, 32'h0, 4'hF);
    wr(A_MTIME, 32'h4, 4'hF);
    check("irq_before", {31'h0, mip_mtip}, 32'h0);
    idle(23);
    check("irq_pre_tick", {31'h0, mip_mtip}, 32'h0);
    idle(1);
    check("irq_rise", {31'h0, mip_mtip}, 32'h1);
    wr(A_CMPH, 32'h1, 4'hF);
    check("irq_drop", {31'h0, mip_mtip}, 32'h0);
    rd(A_MTIME, 32'h5);

    // Collision: write on the tick cycle wins, prescaler restarts
    wr(A_MTIME, 32'h0, 4'hF);
    idle(23);
    wr(A_MTIME, 32'h10, 4'hF);
    rd(A_MTIME, 32'h10);
    idle(22);
    rd(A_MTIME, 32'h10);
    rd(A_MTIME, 32'h11);

    // Same-cycle read and write: old value returned, new value stored
    step(A_CMP, 32'h55, 4'hF, 1'b1, 32'h5);
    rd(A_CMP, 32'h55);
    rd(A_CMPH, 32'h1);

    // Mid-operation reset during a pending MTIME read
    idle(1);
    memory_address = A_MTIME;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_hit", {31'h0, read_hit}, 32'h0);
    check("midrst_value", read_value, 32'h0);
    @(posedge clk24);
    #1;
    check("midrst_hit_edge", {31'h0, read_hit}, 32'h0);
    memory_address = 32'h0;
    @(posedge clk24);
    #1;
    reset = 1'b0;
    rd(A_MTIME, 32'h0);
    rd(A_CMP, 32'hFFFFFFFF);
    rd(A_CMPH, 32'hFFFFFFFF);
    check("midrst_mip", {31'h0, mip_mtip}, 32'h0);

    idle(3);
    total++;
    if (q_val.size() != 0) begin
      bad++;
      $display("FAIL pending_reads: got %0d outstanding expected 0", q_val.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
